keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and encodes each key press.
- Drives the same key-event interface the calculator FSM consumes: an 8-bit key code plus a level `pressed` that is held for the duration of a press.
- Sits between the board keypad pins and Calculator_fsm; it is the producer side of the key-code protocol.

---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces the
// selected key and produces an 8-bit key code with a held `pressed` level
// and a one-cycle `key_valid` pulse for the calculator FSM.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [7:0] key_code,
  output logic       pressed,
  output logic       key_valid
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  // Count wide enough for DEBOUNCE_SCANS+1 (release needs one extra sample).
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 2);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] PRESS_CNT   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] RELEASE_CNT = CNT_W'(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       row_q;
  logic [3:0]       colLatch_q;
  logic [7:0]       code_q;
  logic             pressed_q;
  logic             valid_q;
  logic             sample;
  logic             singleLow;
  logic [7:0]       encoded;

  // Position of the single low bit in a row or column pattern.
  function automatic logic [1:0] lowIndex(input logic [3:0] p);
    logic [1:0] idx;
    case (p)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Keypad legend: digits map to their value, operators carry 4'hF upper
  // nibble, '=' is E0 and 'C' is C0.
  function automatic logic [7:0] encodeKey(input logic [1:0] r, input logic [1:0] c);
    logic [7:0] code;
    case ({r, c})
      4'b00_00: code = 8'h01;
      4'b00_01: code = 8'h02;
      4'b00_10: code = 8'h03;
      4'b00_11: code = 8'hF0;
      4'b01_00: code = 8'h04;
      4'b01_01: code = 8'h05;
      4'b01_10: code = 8'h06;
      4'b01_11: code = 8'hF1;
      4'b10_00: code = 8'h07;
      4'b10_01: code = 8'h08;
      4'b10_10: code = 8'h09;
      4'b10_11: code = 8'hF2;
      4'b11_00: code = 8'hC0;
      4'b11_01: code = 8'h00;
      4'b11_10: code = 8'hE0;
      4'b11_11: code = 8'hF3;
    endcase
    return code;
  endfunction

  // Sample strobe, divider advance, candidate count and the code of the
  // latched key; a pattern with more than one low column is never accepted.
  always_comb begin
    sample    = (div_q == DIV_LAST);
    div_d     = sample ? '0 : div_q + 1'b1;
    cnt_d     = cnt_q + 1'b1;
    singleLow = (col == 4'b1110) || (col == 4'b1101) ||
                (col == 4'b1011) || (col == 4'b0111);
    encoded   = encodeKey(lowIndex(row_q), lowIndex(colLatch_q));
  end

  // Free-running row-period divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Scan / debounce / hold FSM with registered outputs. On release the first
  // all-high sample plays the role the detecting sample plays on press, so
  // both edges take DEBOUNCE_SCANS row periods after the first changed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      row_q      <= 4'b1110;
      colLatch_q <= 4'hF;
      cnt_q      <= '0;
      code_q     <= 8'hFF;
      pressed_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (sample) begin
        unique case (state_q)
          SCAN: begin
            if (singleLow) begin
              colLatch_q <= col;
              cnt_q      <= '0;
              state_q    <= DEBOUNCE;
            end else begin
              row_q <= {row_q[2:0], row_q[3]};
            end
          end
          DEBOUNCE: begin
            if (col == colLatch_q) begin
              if (cnt_d == PRESS_CNT) begin
                code_q    <= encoded;
                pressed_q <= 1'b1;
                valid_q   <= 1'b1;
                cnt_q     <= '0;
                state_q   <= HELD;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (col == 4'hF) begin
              if (cnt_d == RELEASE_CNT) begin
                code_q    <= 8'hFF;
                pressed_q <= 1'b0;
                cnt_q     <= '0;
                state_q   <= SCAN;
              end else begin
                cnt_q <= cnt_d;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign row       = row_q;
  assign key_code  = code_q;
  assign pressed   = pressed_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, behavioural reference model with a
// per-cycle compare, and directed key sequences with literal expectations.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] key_code;
  logic       pressed;
  logic       key_valid;

  int         keyRow = -1;
  logic [3:0] keyColMask = 4'h0;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int sampleCnt = 0;
  int validCount = 0;

  // Reference model state
  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  int         mDiv = 0;
  int         mRowIdx = 0;
  int         mMode = M_SCAN;
  int         mRun = 0;
  logic [3:0] mLatCol = 4'hF;
  logic [7:0] mCode = 8'hFF;
  logic       mPressed = 1'b0;
  logic       mValid = 1'b0;
  int         detCyc = -1000;
  int         firstHighCyc = -1000;
  bit         modelReady = 1'b0;

  logic [7:0] keyTable [4][4] = '{
    '{8'h01, 8'h02, 8'h03, 8'hF0},
    '{8'h04, 8'h05, 8'h06, 8'hF1},
    '{8'h07, 8'h08, 8'h09, 8'hF2},
    '{8'hC0, 8'h00, 8'hE0, 8'hF3}
  };

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .key_code(key_code), .pressed(pressed), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rowPattern(input int r);
    logic [3:0] p;
    p = 4'b0001 << r;
    return ~p;
  endfunction

  function automatic int zeroIndex(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  // Physical keypad: the held key pulls its columns low only while its row is driven.
  assign col = (keyRow >= 0 && row == rowPattern(keyRow)) ? ~keyColMask : 4'hF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference model: one column sample per SD clocks; a key is accepted after
  // DS+1 consecutive identical single-low samples and released after DS+1
  // consecutive all-high samples.
  always @(posedge clk) begin : modelProc
    int lows;
    cyc++;
    if (rst) begin
      mDiv = 0; mRowIdx = 0; mMode = M_SCAN; mRun = 0;
      mCode = 8'hFF; mPressed = 1'b0; mValid = 1'b0;
      modelReady = 1'b1;
    end else begin
      mValid = 1'b0;
      if (mDiv == SD - 1) begin
        mDiv = 0;
        sampleCnt++;
        lows = 0;
        for (int i = 0; i < 4; i++) if (!col[i]) lows++;
        if (mMode == M_SCAN) begin
          if (lows == 1) begin
            mLatCol = col; mRun = 1; mMode = M_DEB; detCyc = cyc;
          end else begin
            mRowIdx = (mRowIdx + 1) % 4;
          end
        end else if (mMode == M_DEB) begin
          if (col == mLatCol) begin
            mRun++;
            if (mRun == DS + 1) begin
              mCode = keyTable[mRowIdx][zeroIndex(mLatCol)];
              mPressed = 1'b1; mValid = 1'b1; mMode = M_HELD; mRun = 0;
            end
          end else begin
            mRun = 0; mMode = M_SCAN;
          end
        end else begin
          if (col == 4'hF) begin
            if (mRun == 0) firstHighCyc = cyc;
            mRun++;
            if (mRun == DS + 1) begin
              mCode = 8'hFF; mPressed = 1'b0; mMode = M_SCAN; mRun = 0;
            end
          end else begin
            mRun = 0;
          end
        end
      end else begin
        mDiv++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("row", 32'(row), 32'(rowPattern(mRowIdx)));
      checkOutput("key_code", 32'(key_code), 32'(mCode));
      checkOutput("pressed", 32'(pressed), 32'(mPressed));
      checkOutput("key_valid", 32'(key_valid), 32'(mValid));
      if (key_valid) validCount++;
    end
  end

  task automatic applyStimulus(input int r, input logic [3:0] mask);
    keyRow = r;
    keyColMask = mask;
  endtask

  task automatic waitLevel(input logic lvl, input int budget, input string name, output int edgeAt);
    int n = 0;
    edgeAt = -1;
    while (pressed !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pressed === lvl) edgeAt = cyc;
    checkOutput(name, 32'(pressed), 32'(lvl));
  endtask

  task automatic waitSamples(input int n);
    int s0 = sampleCnt;
    int guard = 0;
    while (sampleCnt - s0 < n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic pressAndRelease(input int r, input logic [3:0] mask,
                                 input logic [7:0] expCode, input string name);
    int v0, e;
    v0 = validCount;
    applyStimulus(r, mask);
    waitLevel(1'b1, 100, {name, "_rise"}, e);
    checkOutput({name, "_code"}, 32'(key_code), 32'(expCode));
    repeat (80) @(negedge clk);
    checkOutput({name, "_pulses"}, 32'(validCount - v0), 32'd1);
    applyStimulus(-1, 4'h0);
    waitLevel(1'b0, 100, {name, "_fall"}, e);
    checkOutput({name, "_idle"}, 32'(key_code), 32'hFF);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e, riseEdge, fallEdge, v0, guard;
    logic [3:0] rowsSeen;
    bit pressedSeen;

    // Reset state and idle rotation
    repeat (3) @(negedge clk);
    checkOutput("rst_row", 32'(row), 32'hE);
    checkOutput("rst_code", 32'(key_code), 32'hFF);
    checkOutput("rst_pressed", 32'(pressed), 32'd0);
    checkOutput("rst_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("idle_row", 32'(row), 32'(rowPattern(i / 4)));
      @(negedge clk);
    end

    // Key '7' with press and release latency
    v0 = validCount;
    applyStimulus(2, 4'b0001);
    waitLevel(1'b1, 100, "k7_rise", riseEdge);
    checkOutput("k7_latency", 32'(riseEdge - detCyc), 32'd12);
    checkOutput("k7_code", 32'(key_code), 32'h07);
    checkOutput("k7_row", 32'(row), 32'hB);
    repeat (40) @(negedge clk);
    checkOutput("k7_pulses", 32'(validCount - v0), 32'd1);
    checkOutput("k7_rowhold", 32'(row), 32'hB);
    applyStimulus(-1, 4'h0);
    waitLevel(1'b0, 100, "k7_fall", fallEdge);
    checkOutput("k7_rel_latency", 32'(fallEdge - firstHighCyc), 32'd12);
    checkOutput("k7_idle", 32'(key_code), 32'hFF);

    // Operator and function keys
    pressAndRelease(0, 4'b1000, 8'hF0, "plus");
    pressAndRelease(3, 4'b0100, 8'hE0, "equals");
    pressAndRelease(3, 4'b0001, 8'hC0, "clear");

    // Ghost pattern col=1100 on row 0 is never accepted
    v0 = validCount;
    rowsSeen = 4'h0;
    pressedSeen = 1'b0;
    applyStimulus(0, 4'b0011);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rowsSeen[zeroIndex(row)] = 1'b1;
      if (pressed) pressedSeen = 1'b1;
    end
    checkOutput("ghost_pulses", 32'(validCount - v0), 32'd0);
    checkOutput("ghost_pressed", 32'(pressedSeen), 32'd0);
    checkOutput("ghost_rows", 32'(rowsSeen), 32'hF);
    applyStimulus(-1, 4'h0);

    // Bounce on key '5': two low samples, one high, then stable
    guard = 0;
    while (row == 4'b1101 && guard < 40) begin @(negedge clk); guard++; end
    guard = 0;
    while (row != 4'b1101 && guard < 40) begin @(negedge clk); guard++; end
    checkOutput("bounce_align", 32'(row), 32'hD);
    v0 = validCount;
    applyStimulus(1, 4'b0010);
    waitSamples(2);
    applyStimulus(-1, 4'h0);
    waitSamples(1);
    checkOutput("bounce_abort_pressed", 32'(pressed), 32'd0);
    checkOutput("bounce_abort_pulses", 32'(validCount - v0), 32'd0);
    pressAndRelease(1, 4'b0010, 8'h05, "five");
    checkOutput("bounce_total_pulses", 32'(validCount - v0), 32'd1);

    // Reset while key '9' is held, then re-detection
    applyStimulus(2, 4'b0100);
    waitLevel(1'b1, 100, "k9_rise", e);
    checkOutput("k9_code", 32'(key_code), 32'h09);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_pressed", 32'(pressed), 32'd0);
    checkOutput("midrst_code", 32'(key_code), 32'hFF);
    checkOutput("midrst_row", 32'(row), 32'hE);
    rst = 1'b0;
    waitLevel(1'b1, 100, "k9_redetect", e);
    checkOutput("k9_recode", 32'(key_code), 32'h09);
    applyStimulus(-1, 4'h0);
    waitLevel(1'b0, 100, "k9_fall", e);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
